// File: rtl/sound_sequencer.sv
// rtl/sound_sequencer.sv - event-driven melody player and priority arbiter for the tone generator
module sound_sequencer #(
  parameter int NOTE_W = 4,
  parameter int DUR_W  = 6
) (
  input  logic              clk,
  input  logic              resetN,
  input  logic              startOfFrame,
  input  logic              soundOn,
  input  logic              winPulse,
  input  logic              losePulse,
  input  logic              scoredPulse,
  input  logic              collisionPulse,
  output logic              enable_sound,
  output logic [NOTE_W-1:0] freq,
  output logic              busy
);

  typedef enum logic {S_IDLE, S_PLAY} state_t;

  localparam int ROM_W = NOTE_W + DUR_W + 1;

  state_t            state, stateNext;
  logic [1:0]        cur, curNext;
  logic [1:0]        idx, idxNext;
  logic [DUR_W-1:0]  dcnt, dcntNext;
  logic [3:0]        pending, pendingNext;
  logic [NOTE_W-1:0] freqNext;
  logic              enableNext, busyNext;

  logic [3:0]        events, cand;
  logic [1:0]        hp, startId;
  logic              doStart, noteDone, lastNote;
  logic [ROM_W-1:0]  curNote, nextNote, firstNote;

  assign events = {winPulse, losePulse, scoredPulse, collisionPulse};
  assign cand   = events | pending;

  function automatic logic [1:0] topId(input logic [3:0] v);
    if (v[3])      return 2'd3;
    else if (v[2]) return 2'd2;
    else if (v[1]) return 2'd1;
    else           return 2'd0;
  endfunction

  // Entry layout: {last note of melody, frequency index, duration in frames}
  function automatic logic [ROM_W-1:0] noteRom(input logic [1:0] mel, input logic [1:0] n);
    int  f, d;
    logic last;
    last = 1'b0;
    case ({mel, n})
      4'b11_00: begin f = 1;  d = 12; end
      4'b11_01: begin f = 3;  d = 12; end
      4'b11_10: begin f = 5;  d = 12; end
      4'b11_11: begin f = 8;  d = 24; last = 1'b1; end
      4'b10_00: begin f = 9;  d = 20; end
      4'b10_01: begin f = 7;  d = 20; end
      4'b10_10: begin f = 4;  d = 40; last = 1'b1; end
      4'b01_00: begin f = 7;  d = 6;  end
      4'b01_01: begin f = 10; d = 6;  last = 1'b1; end
      4'b00_00: begin f = 5;  d = 4;  last = 1'b1; end
      default:  begin f = 0;  d = 1;  last = 1'b1; end
    endcase
    return {last, NOTE_W'(f), DUR_W'(d)};
  endfunction

  always_comb begin
    stateNext   = state;
    curNext     = cur;
    idxNext     = idx;
    dcntNext    = dcnt;
    pendingNext = pending;
    freqNext    = freq;
    enableNext  = enable_sound;
    busyNext    = busy;
    doStart     = 1'b0;
    hp          = topId(events);
    startId     = hp;
    curNote     = noteRom(cur, idx);
    nextNote    = noteRom(cur, idx + 2'd1);
    lastNote    = curNote[ROM_W-1];
    noteDone    = startOfFrame && (dcnt == DUR_W'(1));

    if (!soundOn) begin
      stateNext   = S_IDLE;
      idxNext     = '0;
      dcntNext    = '0;
      pendingNext = '0;
      freqNext    = '0;
      enableNext  = 1'b0;
      busyNext    = 1'b0;
    end else if (state == S_IDLE || (noteDone && lastNote)) begin
      // Idle and melody end share one arbitration over new pulses plus pending bits
      if (cand != 4'd0) begin
        doStart     = 1'b1;
        startId     = topId(cand);
        pendingNext = cand & ~(4'd1 << topId(cand));
      end else begin
        stateNext  = S_IDLE;
        idxNext    = '0;
        dcntNext   = '0;
        freqNext   = '0;
        enableNext = 1'b0;
        busyNext   = 1'b0;
      end
    end else if (events != 4'd0 && hp >= cur) begin
      doStart     = 1'b1;
      pendingNext = pending | (events & ~(4'd1 << hp));
    end else begin
      pendingNext = pending | events;
      if (noteDone) begin
        idxNext  = idx + 2'd1;
        dcntNext = nextNote[DUR_W-1:0];
        freqNext = nextNote[ROM_W-2:DUR_W];
      end else if (startOfFrame) begin
        dcntNext = dcnt - DUR_W'(1);
      end
    end

    firstNote = noteRom(startId, 2'd0);
    if (doStart) begin
      stateNext  = S_PLAY;
      curNext    = startId;
      idxNext    = '0;
      dcntNext   = firstNote[DUR_W-1:0];
      freqNext   = firstNote[ROM_W-2:DUR_W];
      enableNext = 1'b1;
      busyNext   = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state        <= S_IDLE;
      cur          <= '0;
      idx          <= '0;
      dcnt         <= '0;
      pending      <= '0;
      freq         <= '0;
      enable_sound <= 1'b0;
      busy         <= 1'b0;
    end else begin
      state        <= stateNext;
      cur          <= curNext;
      idx          <= idxNext;
      dcnt         <= dcntNext;
      pending      <= pendingNext;
      freq         <= freqNext;
      enable_sound <= enableNext;
      busy         <= busyNext;
    end
  end

endmodule
